pattern_busy_timer: RTL and testbench
=====================================

// Module: pattern_busy_timer
// PURPOSE
//  Sits directly downstream of the best-1-of-7 1/2-strip pattern sorter and closes its busy loop.
//  - Qualifies the sorter's winning pattern against a hit threshold.
//  - Registers the winner as the CLCT candidate.
//  - Runs one dead-time down-counter per CFEB key group.
//  - Counters drive the sorter's bsy0..bsy6 inputs, so a group (and a neighbour near its edge)
//    stays blocked for a programmable number of clocks after it fires.
// PARAMETERS
//  MXCFEB   7  number of key groups (CFEBs); bsy width
//  MXKEYB   5  key bits within a group (32 1/2-strips per group)
//  MXKEYBX  8  full key width = {group[2:0], key[4:0]}
//  MXPATB   7  pattern word width; [6:4] = layer hit count, [3:0] = pattern id
//  MXDEADB  4  dead-time counter width
//  SPAN     4  1/2-strips from a group edge within which the adjacent group is also blocked
// PORTS
//  clock        in   1        system clock
//  reset        in   1        synchronous, active-high reset
//  enable       in   1        1 = accept sorter winners; 0 = accept nothing, counters keep running
//  hit_thresh   in   3        minimum pattern hits (best_pat[6:4]) to accept
//  dead_time    in   MXDEADB  busy duration in clocks; 0 = busy never asserted
//  best_pat     in   MXPATB   sorter winning pattern
//  best_key     in   MXKEYBX  sorter winning key {group, key}
//  best_bsy     in   1        sorter found no non-busy candidate
//  bsy          out  MXCFEB   per-group busy, to sorter bsy0..bsy6 (bit g = group g)
//  clct_vld     out  1        registered: candidate accepted last cycle
//  clct_pat     out  MXPATB   registered accepted pattern
//  clct_key     out  MXKEYBX  registered accepted key
//  trig_count   out  16       saturating count of accepted candidates
// BEHAVIOUR
//  Reset (synchronous, active-high)
//  - All outputs and counters are 0 on the clock after reset is high.
//  - Reset mid-operation clears every counter; bsy = 0 on that edge; any same-cycle accept is discarded.
//  Accept (combinational, cycle N)
//  - accept = enable & !best_bsy & (best_pat[6:4] >= hit_thresh) & (grp != 7)
//  - grp = best_key[7:5], k = best_key[4:0].
//  - grp == 7 is illegal and never accepted.
//  - hit_thresh == 0 accepts any non-busy winner, including pat == 0.
//  Output register (edge ending cycle N; latency 1 clock)
//  - clct_vld <= accept.
//  - clct_pat/clct_key <= best_pat/best_key when accept, else 0.
//  - trig_count increments on accept and holds at 16'hFFFF.
//  Dead-time counters cnt[g], MXDEADB bits (same edge)
//  - load[g] = accept & ((g == grp)
//      | (g == grp-1 & k < SPAN & grp > 0)
//      | (g == grp+1 & k >= 32-SPAN & grp < MXCFEB-1)).
//  - load[g] -> cnt[g] <= dead_time (a retrigger reloads and extends; no max compare).
//  - else cnt[g] != 0 -> cnt[g] - 1, else hold 0.
//  - Counters never wrap below 0.
//  - bsy[g] = (cnt[g] != 0), driven combinationally from registered state (no extra register).
//  - Accept in cycle N gives bsy[grp] high in cycles N+1 .. N+dead_time.
//  - The sorter sees the block from cycle N+1.
//  - A dead_time change takes effect on the next load only.
//  - Edge groups: group 0 never blocks a lower neighbour; group 6 never blocks a higher one.
//  - SPAN = 0 disables neighbour blocking.
//  - Simultaneous load and decrement: load wins.
//  - enable low: no loads and no clct_vld; running counters still expire normally.
// TESTING
//  1. Reset held 3 clocks with random inputs -> bsy=0, clct_vld=0, trig_count=0 after release.
//  2. dead_time=3, hit_thresh=4, best_key=8'h4A (grp2, k=10), pat=7'h5A at cycle 0
//     -> clct_vld=1, clct_key=8'h4A at cycle 1; bsy=7'b0000100 in cycles 1-3, 0 in cycle 4.
//  3. best_key=8'h21 (grp1, k=1), SPAN=4 -> bsy bits 0 and 1 both set.
//     best_key=8'h3E (grp1, k=30) -> bsy bits 1 and 2 both set.
//     best_key=8'hDF (grp6, k=31) -> only bit 6 set.
//  4. pat[6:4]=3 with hit_thresh=4 -> no clct_vld, no bsy.
//     best_bsy=1 or best_key=8'hE0 -> no accept.
//  5. Retrigger grp3 at cycle 2 of a dead_time=4 window -> bsy[3] stays high through cycle 6.
//     Reset at cycle 4 -> bsy cleared at cycle 5.
//  6. Force 65540 accepts -> trig_count saturates and holds at 16'hFFFF.

Source files
------------

// File: rtl/pattern_busy_timer_if.sv
// Sorter-side link: winning pattern/key in, per-group busy back out to the sorter.
interface pattern_busy_timer_if #(
  parameter int MXCFEB  = 7,
  parameter int MXKEYBX = 8,
  parameter int MXPATB  = 7
);
  logic [MXPATB-1:0]  best_pat;
  logic [MXKEYBX-1:0] best_key;
  logic               best_bsy;
  logic [MXCFEB-1:0]  bsy;

  modport master (output best_pat, output best_key, output best_bsy, input bsy);
  modport slave  (input best_pat, input best_key, input best_bsy, output bsy);
endinterface

// File: rtl/pattern_busy_timer.sv
// Qualifies the sorter winner, registers it as the CLCT candidate and runs the
// per-group dead-time counters that feed busy back to the sorter.
module pattern_busy_timer #(
  parameter int MXCFEB  = 7,
  parameter int MXKEYB  = 5,
  parameter int MXKEYBX = 8,
  parameter int MXPATB  = 7,
  parameter int MXDEADB = 4,
  parameter int SPAN    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [2:0]          hit_thresh,
  input  logic [MXDEADB-1:0]  dead_time,
  pattern_busy_timer_if.slave sorter,
  output logic                clct_vld,
  output logic [MXPATB-1:0]   clct_pat,
  output logic [MXKEYBX-1:0]  clct_key,
  output logic [15:0]         trig_count
);

  localparam int GRPB = MXKEYBX - MXKEYB;
  // Neighbour windows; SPAN = 0 makes both comparisons unsatisfiable.
  localparam logic [MXKEYB:0] SPAN_LO = (MXKEYB+1)'(SPAN);
  localparam logic [MXKEYB:0] SPAN_HI = (MXKEYB+1)'((2**MXKEYB) - SPAN);

  logic [GRPB-1:0]   grp;
  logic [MXKEYB:0]   k_ext;
  logic              accept;
  logic [MXCFEB-1:0] load;
  logic [MXCFEB-1:0] bsy_vec;

  assign grp    = sorter.best_key[MXKEYBX-1:MXKEYB];
  assign k_ext  = {1'b0, sorter.best_key[MXKEYB-1:0]};
  assign accept = enable & ~sorter.best_bsy
                & (sorter.best_pat[MXPATB-1:4] >= hit_thresh)
                & ({1'b0, grp} < (GRPB+1)'(MXCFEB));

  genvar gi;
  generate
    for (gi = 0; gi < MXCFEB; gi++) begin : g_grp
      logic [MXDEADB-1:0] cnt_reg;
      logic               from_upper;
      logic               from_lower;

      // Winner in the next group up, near its low edge, also blocks this group.
      if (gi + 1 < MXCFEB) begin : g_up
        assign from_upper = (grp == GRPB'(gi + 1)) & (k_ext < SPAN_LO);
      end else begin : g_no_up
        assign from_upper = 1'b0;
      end

      if (gi > 0) begin : g_dn
        assign from_lower = (grp == GRPB'(gi - 1)) & (k_ext >= SPAN_HI);
      end else begin : g_no_dn
        assign from_lower = 1'b0;
      end

      assign load[gi] = accept & ((grp == GRPB'(gi)) | from_upper | from_lower);

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (load[gi]) begin
          cnt_reg <= dead_time;
        end else if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end

      assign bsy_vec[gi] = (cnt_reg != '0);
    end
  endgenerate

  assign sorter.bsy = bsy_vec;

  always_ff @(posedge clock) begin
    if (reset) begin
      clct_vld   <= 1'b0;
      clct_pat   <= '0;
      clct_key   <= '0;
      trig_count <= '0;
    end else begin
      clct_vld <= accept;
      clct_pat <= accept ? sorter.best_pat : '0;
      clct_key <= accept ? sorter.best_key : '0;
      if (accept && trig_count != 16'hFFFF) begin
        trig_count <= trig_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_busy_timer.sv
// Directed bench for pattern_busy_timer: acceptance, neighbour blocking, retrigger, reset, saturation.
module tb_pattern_busy_timer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  hit_thresh;
  logic [3:0]  dead_time;
  logic        clct_vld;
  logic [6:0]  clct_pat;
  logic [7:0]  clct_key;
  logic [15:0] trig_count;

  int errors = 0;
  int checks = 0;

  pattern_busy_timer_if sif ();

  pattern_busy_timer dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .hit_thresh (hit_thresh),
    .dead_time  (dead_time),
    .sorter     (sif),
    .clct_vld   (clct_vld),
    .clct_pat   (clct_pat),
    .clct_key   (clct_key),
    .trig_count (trig_count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] th, input logic [3:0] dt,
                       input logic [6:0] pat, input logic [7:0] key, input logic bb);
    enable        = en;
    hit_thresh    = th;
    dead_time     = dt;
    sif.best_pat  = pat;
    sif.best_key  = key;
    sif.best_bsy  = bb;
    $display("txn t=%0t en=%0b th=%0d dt=%0d pat=%h key=%h bb=%0b", $time, en, th, dt, pat, key, bb);
  endtask

  // No accept: zero hits against a nonzero threshold.
  task automatic idle;
    enable       = 1'b1;
    hit_thresh   = 3'd4;
    sif.best_pat = '0;
    sif.best_key = '0;
    sif.best_bsy = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 3'($urandom), 4'($urandom), 7'($urandom), 8'($urandom), 1'($urandom));
      tick();
    end
    checks++; if (sif.bsy !== 7'd0) begin errors++; $display("FAIL reset_bsy got=%b exp=%b", sif.bsy, 7'd0); end
    checks++; if (clct_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", clct_vld); end
    checks++; if (trig_count !== 16'd0) begin errors++; $display("FAIL reset_trig got=%h exp=0", trig_count); end
    reset = 1'b0;
    idle();
    tick();
    checks++; if (sif.bsy !== 7'd0) begin errors++; $display("FAIL post_reset_bsy got=%b exp=0", sif.bsy); end
    checks++; if (clct_vld !== 1'b0) begin errors++; $display("FAIL post_reset_vld got=%b exp=0", clct_vld); end
  endtask

  task automatic test_basic;
    logic [6:0] exp_bsy;
    drive(1'b1, 3'd4, 4'd3, 7'h5A, 8'h4A, 1'b0);
    tick();
    idle();
    checks++; if (clct_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got=%b exp=1", clct_vld); end
    checks++; if (clct_key !== 8'h4A) begin errors++; $display("FAIL basic_key got=%h exp=4a", clct_key); end
    checks++; if (clct_pat !== 7'h5A) begin errors++; $display("FAIL basic_pat got=%h exp=5a", clct_pat); end
    checks++; if (trig_count !== 16'd1) begin errors++; $display("FAIL basic_trig got=%h exp=1", trig_count); end
    checks++; if (sif.bsy !== 7'b0000100) begin errors++; $display("FAIL basic_bsy_c1 got=%b exp=0000100", sif.bsy); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      exp_bsy = (c <= 3) ? 7'b0000100 : 7'b0000000;
      checks++; if (sif.bsy !== exp_bsy) begin errors++; $display("FAIL basic_bsy_c%0d got=%b exp=%b", c, sif.bsy, exp_bsy); end
    end
    checks++; if (clct_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_after got=%b exp=0", clct_vld); end
  endtask

  task automatic test_neighbors;
    logic [7:0] keys [8];
    logic [6:0] exps [8];
    keys = '{8'h21, 8'h3E, 8'hDF, 8'h24, 8'h3B, 8'h00, 8'h1F, 8'hC0};
    exps = '{7'b0000011, 7'b0000110, 7'b1000000, 7'b0000010,
             7'b0000010, 7'b0000001, 7'b0000011, 7'b1100000};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'd4, 4'd3, 7'h40, keys[i], 1'b0);
      tick();
      idle();
      checks++; if (sif.bsy !== exps[i]) begin errors++; $display("FAIL neighbor_key%h got=%b exp=%b", keys[i], sif.bsy, exps[i]); end
      repeat (3) tick();
      checks++; if (sif.bsy !== 7'd0) begin errors++; $display("FAIL neighbor_clear_key%h got=%b exp=0", keys[i], sif.bsy); end
    end
  endtask

  task automatic test_reject;
    // {en, th, dt, pat, key, bb, exp_vld, exp_bsy}
    logic       en   [9];
    logic [2:0] th   [9];
    logic [3:0] dt   [9];
    logic [6:0] pat  [9];
    logic [7:0] key  [9];
    logic       bb   [9];
    logic       ev   [9];
    logic [6:0] eb   [9];
    en  = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    th  = '{4, 4, 4, 4, 4, 0, 7, 7, 4};
    dt  = '{3, 3, 3, 3, 3, 3, 3, 3, 0};
    pat = '{7'h3F, 7'h70, 7'h70, 7'h70, 7'h40, 7'h00, 7'h7F, 7'h6F, 7'h50};
    key = '{8'h4A, 8'h4A, 8'hE0, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
    bb  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    ev  = '{0, 0, 0, 0, 1, 1, 1, 0, 1};
    eb  = '{7'd0, 7'd0, 7'd0, 7'd0, 7'b0000100, 7'b0000100, 7'b0000100, 7'd0, 7'd0};
    for (int i = 0; i < 9; i++) begin
      drive(en[i], th[i], dt[i], pat[i], key[i], bb[i]);
      tick();
      idle();
      checks++; if (clct_vld !== ev[i]) begin errors++; $display("FAIL reject%0d_vld got=%b exp=%b", i, clct_vld, ev[i]); end
      checks++; if (clct_key !== (ev[i] ? key[i] : 8'h00)) begin errors++; $display("FAIL reject%0d_key got=%h exp=%h", i, clct_key, ev[i] ? key[i] : 8'h00); end
      checks++; if (sif.bsy !== eb[i]) begin errors++; $display("FAIL reject%0d_bsy got=%b exp=%b", i, sif.bsy, eb[i]); end
      repeat (3) tick();
    end
  endtask

  task automatic test_retrigger;
    logic exp_b;
    drive(1'b1, 3'd4, 4'd4, 7'h50, 8'h6A, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 2) drive(1'b1, 3'd4, 4'd4, 7'h50, 8'h6A, 1'b0);
      else idle();
      exp_b = (c <= 6);
      checks++; if (sif.bsy[3] !== exp_b) begin errors++; $display("FAIL retrig_bsy3_c%0d got=%b exp=%b", c, sif.bsy[3], exp_b); end
    end
  endtask

  task automatic test_enable_low;
    logic exp_b;
    drive(1'b1, 3'd4, 4'd3, 7'h50, 8'h6A, 1'b0);
    tick();
    drive(1'b0, 3'd4, 4'd3, 7'h50, 8'h6A, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      exp_b = (c <= 3);
      checks++; if (sif.bsy[3] !== exp_b) begin errors++; $display("FAIL enlow_bsy3_c%0d got=%b exp=%b", c, sif.bsy[3], exp_b); end
      checks++; if (clct_vld !== 1'b0) begin errors++; $display("FAIL enlow_vld_c%0d got=%b exp=0", c, clct_vld); end
    end
    idle();
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 3'd4, 4'd4, 7'h50, 8'h6A, 1'b0);
    tick();
    idle();
    repeat (3) tick();
    checks++; if (sif.bsy[3] !== 1'b1) begin errors++; $display("FAIL rstmid_bsy3_c4 got=%b exp=1", sif.bsy[3]); end
    reset = 1'b1;
    drive(1'b1, 3'd4, 4'd4, 7'h50, 8'h6A, 1'b0);
    tick();
    checks++; if (sif.bsy !== 7'd0) begin errors++; $display("FAIL rstmid_bsy_c5 got=%b exp=0", sif.bsy); end
    checks++; if (clct_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld_c5 got=%b exp=0", clct_vld); end
    checks++; if (trig_count !== 16'd0) begin errors++; $display("FAIL rstmid_trig got=%h exp=0", trig_count); end
    reset = 1'b0;
    idle();
    tick();
    checks++; if (sif.bsy !== 7'd0) begin errors++; $display("FAIL rstmid_bsy_c6 got=%b exp=0", sif.bsy); end
  endtask

  task automatic test_saturate;
    drive(1'b1, 3'd4, 4'd0, 7'h70, 8'h4A, 1'b0);
    repeat (65534) @(posedge clock);
    #1;
    checks++; if (trig_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got=%h exp=fffe", trig_count); end
    tick();
    checks++; if (trig_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got=%h exp=ffff", trig_count); end
    repeat (5) tick();
    checks++; if (trig_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", trig_count); end
    checks++; if (sif.bsy !== 7'd0) begin errors++; $display("FAIL sat_dt0_bsy got=%b exp=0", sif.bsy); end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    dead_time = '0;
    idle();
    test_reset();
    test_basic();
    test_neighbors();
    test_reject();
    test_retrigger();
    test_enable_low();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
